// File: rtl/lap_timer_pkg.sv
// Shared types and helpers for the lap timer: FSM states, BCD digit type, prescaler terminal count.
package lap_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    RUN_LAP,
    PAUSE_LAP
  } lap_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic int prescale_max(input int clk_hz, input int tick_hz);
    return (clk_hz / tick_hz) - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the cascade: steps on en, loads a clamped preset, reports carry/borrow to the next digit.
// Down-count (borrow) logic exists only when DOWN_EN is set.
module bcd_digit_counter
  import lap_timer_pkg::*;
#(
  parameter bit DOWN_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       down,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t q,
  output logic       co
);

  logic at_end;
  logic step_down;

  if (DOWN_EN) begin : g_dn
    assign step_down = down;
    assign at_end    = down ? (q == 4'd0) : (q == BCD_MAX);
  end else begin : g_up
    logic unused_down;
    assign unused_down = down;
    assign step_down   = 1'b0;
    assign at_end      = (q == BCD_MAX);
  end

  assign co = en & at_end;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= (load_val > BCD_MAX) ? BCD_MAX : load_val;
    end else if (en) begin
      if (step_down) q <= at_end ? BCD_MAX : q - 4'd1;
      else           q <= at_end ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/lap_timer_core.sv
// Lap timer: prescaled tick drives an N-digit BCD cascade with lap freeze and a saturating wrap counter.
// Down-count mode (load_value preset, done pulse) is built only when LAP_TIMER_COUNTDOWN_EN is defined.
module lap_timer_core
  import lap_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int NUM_DIGITS  = 4,
  parameter int FRAC_DIGITS = 2,
  parameter int WRAP_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    lap,
  input  logic                    clear,
  input  logic                    mode_down,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    lap_active,
  output logic [WRAP_BITS-1:0]    wrap_count,
  output logic                    done
);

  localparam int            PMAX  = prescale_max(CLK_FREQ_HZ, TICK_HZ);
  localparam int            PW    = (PMAX > 0) ? $clog2(PMAX + 1) : 1;
  localparam logic [PW-1:0] PTERM = PW'(PMAX);
  localparam int            DW    = 4 * NUM_DIGITS;
  localparam int            unused_frac = FRAC_DIGITS;

  lap_state_t          state, nstate;
  logic [PW-1:0]       presc;
  logic [DW-1:0]       count, lap_reg;
  logic [NUM_DIGITS:0] carry;
  logic c_stop, c_start, c_lap;
  logic tick, zero_hit, wrap_hit, dir_down, load_now;

  // Only the highest-priority pulse of a cycle is acted on.
  assign c_stop   = stop & ~clear;
  assign c_start  = start & ~stop & ~clear;
  assign c_lap    = lap & ~start & ~stop & ~clear;
  assign tick     = running && (presc == PTERM);
  assign zero_hit = dir_down && running && (count == '0);
  assign carry[0] = tick && !zero_hit;
  assign wrap_hit = carry[NUM_DIGITS] && !dir_down;

`ifdef LAP_TIMER_COUNTDOWN_EN
  localparam bit DOWN_EN = 1'b1;
  logic done_q;
  assign load_now = (state == IDLE) && c_start && mode_down;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dir_down <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= zero_hit;
      if (state == IDLE && c_start) dir_down <= mode_down;
    end
  end
`else
  localparam bit DOWN_EN = 1'b0;
  logic unused_mode;
  assign unused_mode = mode_down;
  assign load_now    = 1'b0;
  assign dir_down    = 1'b0;
  assign done        = 1'b0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_counter #(.DOWN_EN(DOWN_EN)) u_digit (
      .clk      (clk),
      .reset    (reset),
      .clr      (clear),
      .en       (carry[g]),
      .down     (dir_down),
      .load     (load_now),
      .load_val (load_value[4*g +: 4]),
      .q        (count[4*g +: 4]),
      .co       (carry[g+1])
    );
  end

  always_comb begin
    nstate = state;
    if (clear || zero_hit) begin
      nstate = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (c_start) nstate = RUN;
        RUN:       if (c_stop) nstate = PAUSE;
                   else if (c_lap) nstate = RUN_LAP;
        PAUSE:     if (c_start) nstate = RUN;
        RUN_LAP:   if (c_stop) nstate = PAUSE_LAP;
                   else if (c_lap) nstate = RUN;
        PAUSE_LAP: if (c_start) nstate = RUN_LAP;
                   else if (c_lap) nstate = PAUSE;
        default:   nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      presc      <= '0;
      lap_reg    <= '0;
      display    <= '0;
      wrap_count <= '0;
    end else begin
      state      <= nstate;
      running    <= (nstate == RUN) || (nstate == RUN_LAP);
      lap_active <= (nstate == RUN_LAP) || (nstate == PAUSE_LAP);
      // Prescaler holds while paused so a resume continues mid-tick.
      if (state == IDLE)  presc <= '0;
      else if (running)   presc <= tick ? '0 : presc + 1'b1;
      if (state == RUN && c_lap) lap_reg <= count;
      display <= lap_active ? lap_reg : count;
      if (wrap_hit && wrap_count != '1) wrap_count <= wrap_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lap_timer_core.sv
// Scoreboard bench: stimulus queues expected outputs per target cycle, a negedge monitor pops and compares.
module tb_lap_timer_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_start = 0, a_stop = 0, a_lap = 0, a_clear = 0, a_mode = 0;
  logic [15:0] a_load = '0;
  logic [15:0] a_display;
  logic        a_running, a_lap_active, a_done;
  logic [15:0] a_wrap;

  logic        b_start = 0, b_stop = 0, b_lap = 0, b_clear = 0, b_mode = 0;
  logic [7:0]  b_load = '0;
  logic [7:0]  b_display;
  logic        b_running, b_lap_active, b_done;
  logic [1:0]  b_wrap;

  lap_timer_core #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4), .FRAC_DIGITS(2), .WRAP_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .lap(a_lap), .clear(a_clear),
    .mode_down(a_mode), .load_value(a_load), .display(a_display), .running(a_running),
    .lap_active(a_lap_active), .wrap_count(a_wrap), .done(a_done));

  lap_timer_core #(.CLK_FREQ_HZ(200), .TICK_HZ(100), .NUM_DIGITS(2), .FRAC_DIGITS(1), .WRAP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .lap(b_lap), .clear(b_clear),
    .mode_down(b_mode), .load_value(b_load), .display(b_display), .running(b_running),
    .lap_active(b_lap_active), .wrap_count(b_wrap), .done(b_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          inst;
    string       name;
    logic [15:0] disp;
    logic        run;
    logic        lp;
    logic        dn;
    logic [15:0] wrap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input bit inst, input int dt, input string nm, input logic [15:0] d,
                      input logic r, input logic l, input logic dn, input logic [15:0] w);
    exp_t e;
    int   i;
    e.cyc = cyc + dt; e.inst = inst; e.name = nm;
    e.disp = d; e.run = r; e.lp = l; e.dn = dn; e.wrap = w;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  exp_t        m_e;
  logic [15:0] m_d, m_w;
  logic        m_r, m_l, m_dn;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      if (m_e.inst) begin
        m_d = {8'h00, b_display}; m_r = b_running; m_l = b_lap_active; m_dn = b_done; m_w = {14'd0, b_wrap};
      end else begin
        m_d = a_display; m_r = a_running; m_l = a_lap_active; m_dn = a_done; m_w = a_wrap;
      end
      n_cmp++;
      if (m_d !== m_e.disp || m_r !== m_e.run || m_l !== m_e.lp || m_dn !== m_e.dn || m_w !== m_e.wrap) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got disp=%h run=%b lap=%b done=%b wrap=%0d, want disp=%h run=%b lap=%b done=%b wrap=%0d",
                 m_e.name, cyc, m_d, m_r, m_l, m_dn, m_w, m_e.disp, m_e.run, m_e.lp, m_e.dn, m_e.wrap);
      end
    end
  end

  // Drive one command for one cycle; returns just after the edge that sampled it.
  task automatic cmd(input bit inst, input bit s, input bit st, input bit l, input bit c);
    if (inst) begin b_start = s; b_stop = st; b_lap = l; b_clear = c; end
    else      begin a_start = s; a_stop = st; a_lap = l; a_clear = c; end
    @(posedge clk); #1;
    a_start = 0; a_stop = 0; a_lap = 0; a_clear = 0;
    b_start = 0; b_stop = 0; b_lap = 0; b_clear = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    push(0, 0, "a_reset", 16'h0000, 0, 0, 0, 0);
    push(1, 0, "b_reset", 16'h0000, 0, 0, 0, 0);

    // Run, pause, then resume from prescaler phase 6: next count step 4 clocks later.
    cmd(0, 1, 0, 0, 0);
    push(0, 1235, "count_0123", 16'h0123, 1, 0, 0, 0);
    idle(1235);
    cmd(0, 0, 1, 0, 0);
    push(0, 0,   "stop_now",  16'h0123, 0, 0, 0, 0);
    push(0, 100, "stop_hold", 16'h0123, 0, 0, 0, 0);
    idle(100);
    cmd(0, 1, 0, 0, 0);
    push(0, 4, "resume_t4", 16'h0123, 1, 0, 0, 0);
    push(0, 5, "resume_t5", 16'h0124, 1, 0, 0, 0);
    idle(5);
    cmd(0, 0, 0, 0, 1);
    push(0, 0, "clear", 16'h0000, 0, 0, 0, 0);

    // Lap freeze at 0x0050, release shows the live 0x0070.
    cmd(0, 1, 0, 0, 0);
    idle(504);
    cmd(0, 0, 0, 1, 0);
    push(0, 0,   "lap_on",   16'h0050, 1, 1, 0, 0);
    push(0, 200, "lap_hold", 16'h0050, 1, 1, 0, 0);
    idle(200);
    cmd(0, 0, 0, 1, 0);
    push(0, 0, "lap_off0", 16'h0050, 1, 0, 0, 0);
    push(0, 1, "lap_off1", 16'h0070, 1, 0, 0, 0);
    idle(1);

    // Priority: stop beats start, clear beats start.
    cmd(0, 1, 1, 0, 0);
    push(0, 0,  "stopstart",      16'h0070, 0, 0, 0, 0);
    push(0, 20, "stopstart_hold", 16'h0070, 0, 0, 0, 0);
    idle(20);
    cmd(0, 1, 0, 0, 1);
    push(0, 0,  "clearstart",      16'h0000, 0, 0, 0, 0);
    push(0, 15, "clearstart_hold", 16'h0000, 0, 0, 0, 0);
    idle(15);

    // Reset from RUN_LAP.
    cmd(0, 1, 0, 0, 0);
    idle(29);
    cmd(0, 0, 0, 1, 0);
    push(0, 0, "runlap", 16'h0002, 1, 1, 0, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    push(0, 0, "reset_runlap", 16'h0000, 0, 0, 0, 0);

    // Down count from 3; without the feature the same stimulus counts up.
    a_mode = 1; a_load = 16'h0003;
    cmd(0, 1, 0, 0, 0);
`ifdef LAP_TIMER_COUNTDOWN_EN
    push(0, 1,  "dn_load",  16'h0003, 1, 0, 0, 0);
    push(0, 30, "dn_last",  16'h0001, 1, 0, 0, 0);
    push(0, 31, "dn_done",  16'h0000, 0, 0, 1, 0);
    push(0, 32, "dn_done_end", 16'h0000, 0, 0, 0, 0);
    push(0, 45, "dn_idle",  16'h0000, 0, 0, 0, 0);
`else
    push(0, 1,  "up_only1",  16'h0000, 1, 0, 0, 0);
    push(0, 30, "up_only30", 16'h0002, 1, 0, 0, 0);
    push(0, 31, "up_only31", 16'h0003, 1, 0, 0, 0);
    push(0, 32, "up_only32", 16'h0003, 1, 0, 0, 0);
    push(0, 45, "up_only45", 16'h0004, 1, 0, 0, 0);
`endif
    idle(45);
    cmd(0, 0, 0, 0, 1);
    a_load = 16'h00A0;
    cmd(0, 1, 0, 0, 0);
`ifdef LAP_TIMER_COUNTDOWN_EN
    push(0, 2,  "dn_clamp",  16'h0090, 1, 0, 0, 0);
    push(0, 11, "dn_borrow", 16'h0089, 1, 0, 0, 0);
`else
    push(0, 2,  "up_noload2",  16'h0000, 1, 0, 0, 0);
    push(0, 11, "up_noload11", 16'h0001, 1, 0, 0, 0);
`endif
    idle(11);
    cmd(0, 0, 0, 0, 1);
    a_load = 16'h0000;
    cmd(0, 1, 0, 0, 0);
`ifdef LAP_TIMER_COUNTDOWN_EN
    push(0, 0, "ld0_run",  16'h0000, 1, 0, 0, 0);
    push(0, 1, "ld0_done", 16'h0000, 0, 0, 1, 0);
    push(0, 2, "ld0_end",  16'h0000, 0, 0, 0, 0);
`else
    push(0, 0, "up_ld0_0", 16'h0000, 1, 0, 0, 0);
    push(0, 1, "up_ld0_1", 16'h0000, 1, 0, 0, 0);
    push(0, 2, "up_ld0_2", 16'h0000, 1, 0, 0, 0);
`endif
    idle(2);
    cmd(0, 0, 0, 0, 1);
    a_mode = 0;

    // Two-digit instance, 2 clk/tick: wrap at 99->00 and saturation of a 2-bit wrap counter.
    cmd(1, 1, 0, 0, 0);
    push(1, 199, "b_pre_wrap", 16'h0099, 1, 0, 0, 0);
    push(1, 201, "b_wrap1",    16'h0000, 1, 0, 0, 1);
    push(1, 203, "b_after",    16'h0001, 1, 0, 0, 1);
    push(1, 610, "b_wrap3",    16'h0004, 1, 0, 0, 3);
    push(1, 810, "b_wrap_sat", 16'h0004, 1, 0, 0, 3);
    idle(810);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, first=%s", sb.size(), sb[0].name);
      n_cmp += sb.size();
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
